// File: rtl/online_digit_converter_if.sv
// Handshake bundle between the online multiplier's digit-selection slice
// (master) and the on-the-fly digit converter (slave).
interface online_digit_converter_if #(
   parameter int N = 8
) ();
   logic              start;
   logic              z_valid;
   logic [1:0]        z;
   logic              busy;
   logic              done;
   logic signed [N:0] q;
   logic              err;

   modport master (
      output start, z_valid, z,
      input  busy, done, q, err
   );

   modport slave (
      input  start, z_valid, z,
      output busy, done, q, err
   );
endinterface

// File: rtl/online_digit_converter.sv
// On-the-fly converter: turns an MSB-first radix-2 signed-digit stream
// {-1,0,+1} into an (N+1)-bit two's-complement word without a final
// carry-propagate add. After dropping SKIP online-delay digits, each
// accepted digit updates Q (running value) and QM (Q minus one ulp).
module online_digit_converter #(
   parameter int N    = 8,
   parameter int SKIP = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   online_digit_converter_if.slave bus
);

   localparam int CNT_MAX = (N > SKIP) ? N : SKIP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] N_LAST    = CW'(N - 1);
   localparam logic [CW-1:0] SKIP_LAST = (SKIP > 0) ? CW'(SKIP - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SKIP,
      S_CONV,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   // Only the low N bits of Q and QM are kept: the shift discards the top
   // bit every step, so the full N+1-bit value exists only as the step result.
   logic [N-1:0]      qv_q, qv_d;
   logic [N-1:0]      qm_q, qm_d;
   logic signed [N:0] res_q, res_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [N:0]        q_step;
   logic [N-1:0]      qm_step;
   logic              illegal;

   // One on-the-fly step. The illegal code 2'b11 falls into the zero branch.
   function automatic logic [2*N:0] otf_step(input logic [N-1:0] q,
                                             input logic [N-1:0] qm,
                                             input logic [1:0]   z);
      logic [N:0]   qn;
      logic [N-1:0] qmn;
      case (z)
         2'b10: begin
            qn  = {q, 1'b1};
            qmn = {q[N-2:0], 1'b0};
         end
         2'b01: begin
            qn  = {qm, 1'b1};
            qmn = {qm[N-2:0], 1'b0};
         end
         default: begin
            qn  = {q, 1'b0};
            qmn = {qm[N-2:0], 1'b1};
         end
      endcase
      return {qn, qmn};
   endfunction

   assign {q_step, qm_step} = otf_step(qv_q, qm_q, bus.z);
   assign illegal           = (bus.z == 2'b11);

   // Next-state, datapath update and registered-output precomputation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qv_d    = qv_q;
      qm_d    = qm_q;
      res_d   = res_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            qv_d  = '0;
            qm_d  = '1;
            cnt_d = '0;
            if (bus.start) begin
               err_d   = 1'b0;
               state_d = (SKIP == 0) ? S_CONV : S_SKIP;
            end
         end
         S_SKIP: begin
            if (bus.z_valid) begin
               if (illegal) begin
                  err_d = 1'b1;
               end
               if (cnt_q == SKIP_LAST) begin
                  cnt_d   = '0;
                  state_d = S_CONV;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_CONV: begin
            if (bus.z_valid) begin
               if (illegal) begin
                  err_d = 1'b1;
               end
               qv_d = q_step[N-1:0];
               qm_d = qm_step;
               if (cnt_q == N_LAST) begin
                  // Result is captured on the last digit so q and done
                  // appear together in the DONE cycle.
                  res_d   = $signed(q_step);
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_q == S_CONV) && (state_d == S_DONE);
   end

   // State, datapath and output registers; reset aborts any conversion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         qv_q    <= '0;
         qm_q    <= '1;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         qv_q    <= qv_d;
         qm_q    <= qm_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.q    = res_q;
   assign bus.err  = err_q;

endmodule
